// File: rtl/multibyte_add_pkg.sv
// Shared constants and FSM encoding for the byte-serial wide adder.
package multibyte_add_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_eight.sv
// 8-bit ripple adder stage with carry in/out; one byte of the wide sum per use.
module full_adder_eight
    import multibyte_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              c_in,
    output logic [BYTE_W-1:0] sum,
    output logic              c_out
);

    logic [BYTE_W:0] total;

    // Widen by one bit so the carry out falls into the top position.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, c_in};
        sum   = total[BYTE_W-1:0];
        c_out = total[BYTE_W];
    end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial wide adder: operands are accepted once, then fed LSB byte first
// through a single 8-bit adder with the carry chained through a register. Sum
// bytes enter the result register from the top so that after NBYTES steps the
// LSB byte has reached bit 0.
module multibyte_add_sequencer
    import multibyte_add_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);

    localparam int unsigned W     = BYTE_W * NBYTES;
    localparam int unsigned IDX_W = $clog2(NBYTES);

    state_e             state_q;
    state_e             state_d;
    logic [W-1:0]       op_a_q;
    logic [W-1:0]       op_b_q;
    logic [W-1:0]       result_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;

    logic [BYTE_W-1:0]  byte_sum;
    logic               byte_cout;
    logic               accept;
    logic               last_byte;

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    full_adder_eight u_byte_add (
        .a     (op_a_q[BYTE_W-1:0]),
        .b     (op_b_q[BYTE_W-1:0]),
        .c_in  (carry_q),
        .sum   (byte_sum),
        .c_out (byte_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last byte,
    // DONE -> IDLE when the consumer takes the result.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)            state_d = ST_RUN;
            ST_RUN:  if (last_byte)         state_d = ST_DONE;
            ST_DONE: if (out_ready)         state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; in_ready also masked while reset is held.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_sum   = out_valid ? result_q : '0;
        out_cout  = out_valid && carry_q;
    end

    // Operand shift registers, carry chain, byte index and result collection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_a_q   <= in_a;
                        op_b_q   <= in_b;
                        carry_q  <= in_cin;
                        idx_q    <= '0;
                        result_q <= '0;
                    end
                end
                ST_RUN: begin
                    result_q <= {byte_sum, result_q[W-1:BYTE_W]};
                    op_a_q   <= {{BYTE_W{1'b0}}, op_a_q[W-1:BYTE_W]};
                    op_b_q   <= {{BYTE_W{1'b0}}, op_b_q[W-1:BYTE_W]};
                    carry_q  <= byte_cout;
                    if (!last_byte) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    // DONE holds result and carry stable for the consumer.
                end
            endcase
        end
    end

endmodule
